// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Shares data_ram port A between the CPU MEM stage (m0) and a debug/loader
//   master (m1). One access is in flight at a time. Each access runs
//   IDLE -> ISSUE -> WAIT* -> DONE. The WAIT cycles cover the RAM read latency.
//   Ties go to the port that did not win last time.
//
// Ports
//   clk, resetn         clock; async reset, active HIGH despite the name
//   mX_req/wen/addr/wdata  request inputs, wen==0 means read
//   mX_gnt              port owns the RAM (ISSUE/WAIT/DONE)
//   mX_done/rdata       one-cycle completion pulse; rdata valid only with done
//   ram_wen/addr/wdata  to data_ram port A
//   ram_rdata           from data_ram port A
//   busy                an access is in progress
module dram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic [3:0]        m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [3:0]        m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // WAIT lasts RD_LAT-1 cycles. The counter is loaded with RD_LAT-2 and
  // leaves WAIT when it reads 0.
  localparam int         CNT_INIT_I = (RD_LAT >= 2) ? RD_LAT - 2 : 0;
  localparam logic [1:0] CNT_INIT   = 2'(CNT_INIT_I);

  state_t              r_state, w_next;
  logic                r_owner;      // 0 = m0, 1 = m1
  logic                r_last;       // last granted port
  logic [1:0]          r_cnt, w_cnt_nxt;
  logic [3:0]          r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_grant, w_sel;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_grant   = 1'b0;
    w_sel     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          w_grant = 1'b1;
          w_sel   = ~r_last;
        end else if (m0_req) begin
          w_grant = 1'b1;
          w_sel   = 1'b0;
        end else if (m1_req) begin
          w_grant = 1'b1;
          w_sel   = 1'b1;
        end
        if (w_grant) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (RD_LAT == 1) begin
          w_next = S_DONE;
        end else begin
          w_next    = S_WAIT;
          w_cnt_nxt = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) w_next = S_DONE;
        else               w_cnt_nxt = r_cnt - 2'd1;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 2'd0;
      r_wen   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_owner <= w_sel;
        r_last  <= w_sel;
        r_wen   <= w_sel ? m1_wen   : m0_wen;
        r_addr  <= w_sel ? m1_addr  : m0_addr;
        r_wdata <= w_sel ? m1_wdata : m0_wdata;
      end
    end
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    ram_addr  = r_addr;
    ram_wdata = r_wdata;
    ram_wen   = (r_state == S_ISSUE) ? r_wen : 4'd0;
    m0_gnt    = busy && !r_owner;
    m1_gnt    = busy &&  r_owner;
    m0_done   = (r_state == S_DONE) && !r_owner;
    m1_done   = (r_state == S_DONE) &&  r_owner;
    m0_rdata  = m0_done ? ram_rdata : '0;
    m1_rdata  = m1_done ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // RAM preload port, shared by both RAM models
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  // ---------------- DUT a: RD_LAT=1 ----------------
  logic        a0_req, a1_req, a0_gnt, a1_gnt, a0_done, a1_done, a_busy;
  logic [3:0]  a0_wen, a1_wen, a_ram_wen;
  logic [31:0] a0_addr, a1_addr, a0_wdata, a1_wdata, a0_rdata, a1_rdata;
  logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

  dram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_a (
    .clk(clk), .resetn(resetn),
    .m0_req(a0_req), .m0_wen(a0_wen), .m0_addr(a0_addr), .m0_wdata(a0_wdata),
    .m0_gnt(a0_gnt), .m0_done(a0_done), .m0_rdata(a0_rdata),
    .m1_req(a1_req), .m1_wen(a1_wen), .m1_addr(a1_addr), .m1_wdata(a1_wdata),
    .m1_gnt(a1_gnt), .m1_done(a1_done), .m1_rdata(a1_rdata),
    .ram_wen(a_ram_wen), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_rdata(a_ram_rdata), .busy(a_busy));

  logic [31:0] mem_a [256];
  always @(posedge clk) begin
    a_ram_rdata <= mem_a[a_ram_addr[9:2]];
    if (pl_en) mem_a[pl_idx] <= pl_data;
    for (int b = 0; b < 4; b++)
      if (a_ram_wen[b]) mem_a[a_ram_addr[9:2]][b*8 +: 8] <= a_ram_wdata[b*8 +: 8];
  end

  // ---------------- DUT c: RD_LAT=3 ----------------
  logic        c0_req, c1_req, c0_gnt, c1_gnt, c0_done, c1_done, c_busy;
  logic [3:0]  c0_wen, c1_wen, c_ram_wen;
  logic [31:0] c0_addr, c1_addr, c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic [31:0] c_ram_addr, c_ram_wdata, c_ram_rdata;

  dram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_c (
    .clk(clk), .resetn(resetn),
    .m0_req(c0_req), .m0_wen(c0_wen), .m0_addr(c0_addr), .m0_wdata(c0_wdata),
    .m0_gnt(c0_gnt), .m0_done(c0_done), .m0_rdata(c0_rdata),
    .m1_req(c1_req), .m1_wen(c1_wen), .m1_addr(c1_addr), .m1_wdata(c1_wdata),
    .m1_gnt(c1_gnt), .m1_done(c1_done), .m1_rdata(c1_rdata),
    .ram_wen(c_ram_wen), .ram_addr(c_ram_addr), .ram_wdata(c_ram_wdata),
    .ram_rdata(c_ram_rdata), .busy(c_busy));

  logic [31:0] mem_c [256];
  logic [31:0] pc0, pc1;
  always @(posedge clk) begin
    pc0 <= mem_c[c_ram_addr[9:2]];
    pc1 <= pc0;
    c_ram_rdata <= pc1;
    if (pl_en) mem_c[pl_idx] <= pl_data;
    for (int b = 0; b < 4; b++)
      if (c_ram_wen[b]) mem_c[c_ram_addr[9:2]][b*8 +: 8] <= c_ram_wdata[b*8 +: 8];
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    resetn = 1'b1;
    tick(); tick();
    checks++; if ({a_busy, a0_gnt, a1_gnt, a0_done, a1_done} !== 5'b0) begin errs++; $display("FAIL reset_ctl got=%b exp=00000", {a_busy, a0_gnt, a1_gnt, a0_done, a1_done}); end
    checks++; if ({a_ram_wen, a_ram_addr, a_ram_wdata, a0_rdata, a1_rdata} !== '0) begin errs++; $display("FAIL reset_data got=%h/%h/%h exp=0", a_ram_wen, a_ram_addr, a_ram_wdata); end
    checks++; if ({c_busy, c0_gnt, c1_gnt, c_ram_wen} !== 7'b0) begin errs++; $display("FAIL reset_c got=%b exp=0", {c_busy, c0_gnt, c1_gnt, c_ram_wen}); end
    resetn = 1'b0;
  endtask

  task automatic test_read;
    a0_addr = 32'h10; a0_wen = 4'h0; a0_req = 1'b1;
    tick(); // ISSUE
    checks++; if ({a0_gnt, a1_gnt, a_busy, a0_done} !== 4'b1010) begin errs++; $display("FAIL read_issue_ctl got=%b exp=1010", {a0_gnt, a1_gnt, a_busy, a0_done}); end
    checks++; if (a_ram_wen !== 4'h0 || a_ram_addr !== 32'h10) begin errs++; $display("FAIL read_issue_ram got=%h/%h exp=0/10", a_ram_wen, a_ram_addr); end
    tick(); // DONE
    checks++; if (a0_done !== 1'b1 || a0_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL read_done got=%b/%h exp=1/deadbeef", a0_done, a0_rdata); end
    checks++; if ({a1_gnt, a1_done, a1_rdata} !== '0) begin errs++; $display("FAIL read_m1_quiet got=%b/%b/%h exp=0", a1_gnt, a1_done, a1_rdata); end
    a0_req = 1'b0;
    tick(); // IDLE
    checks++; if ({a0_done, a_busy, a0_gnt} !== 3'b0 || a0_rdata !== 32'h0) begin errs++; $display("FAIL read_pulse_end got=%b/%h exp=0", {a0_done, a_busy, a0_gnt}, a0_rdata); end
  endtask

  task automatic test_write_then_read;
    a1_addr = 32'h20; a1_wen = 4'hF; a1_wdata = 32'h12345678; a1_req = 1'b1;
    tick(); // ISSUE
    checks++; if (a_ram_wen !== 4'hF || a1_gnt !== 1'b1 || a_ram_wdata !== 32'h12345678 || a_ram_addr !== 32'h20) begin errs++; $display("FAIL wr_issue got=%h/%b/%h/%h exp=f/1/12345678/20", a_ram_wen, a1_gnt, a_ram_wdata, a_ram_addr); end
    tick(); // DONE
    checks++; if (a_ram_wen !== 4'h0 || a1_done !== 1'b1) begin errs++; $display("FAIL wr_done got=%h/%b exp=0/1", a_ram_wen, a1_done); end
    a1_req = 1'b0;
    tick(); // IDLE
    checks++; if (a_ram_wen !== 4'h0 || a_busy !== 1'b0) begin errs++; $display("FAIL wr_idle got=%h/%b exp=0/0", a_ram_wen, a_busy); end
    a0_addr = 32'h20; a0_wen = 4'h0; a0_req = 1'b1;
    tick(); tick();
    checks++; if (a0_done !== 1'b1 || a0_rdata !== 32'h12345678) begin errs++; $display("FAIL wr_readback got=%b/%h exp=1/12345678", a0_done, a0_rdata); end
    a0_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd;
    resetn = 1'b1; tick(); resetn = 1'b0;
    a0_addr = 32'h10; a0_wen = 4'h0; a1_addr = 32'h20; a1_wen = 4'h0;
    a0_req = 1'b1; a1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_rd = (k % 2 == 0) ? 32'hDEADBEEF : 32'h12345678;
      tick(); // ISSUE
      checks++; if (a0_gnt !== (k % 2 == 0) || a1_gnt !== (k % 2 == 1)) begin errs++; $display("FAIL rr_grant k=%0d got=%b%b exp=%b%b", k, a0_gnt, a1_gnt, k % 2 == 0, k % 2 == 1); end
      tick(); // DONE
      checks++; if (a0_done !== (k % 2 == 0) || a1_done !== (k % 2 == 1) || (a0_rdata | a1_rdata) !== exp_rd || (a0_gnt && a1_gnt)) begin errs++; $display("FAIL rr_done k=%0d got=%b%b/%h exp=%b%b/%h", k, a0_done, a1_done, a0_rdata | a1_rdata, k % 2 == 0, k % 2 == 1, exp_rd); end
      tick(); // IDLE
      checks++; if ({a_busy, a0_gnt, a1_gnt, a0_done, a1_done} !== 5'b0) begin errs++; $display("FAIL rr_idle k=%0d got=%b exp=0", k, {a_busy, a0_gnt, a1_gnt, a0_done, a1_done}); end
    end
    a0_req = 1'b0; a1_req = 1'b0;
    tick();
  endtask

  task automatic test_rdlat3;
    c0_addr = 32'h10; c0_wen = 4'h0; c0_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (c0_done !== (k == 4) || c_ram_wen !== 4'h0 || c0_gnt !== 1'b1 || c_busy !== 1'b1) begin errs++; $display("FAIL lat3 cyc=%0d got done=%b wen=%h gnt=%b exp done=%b wen=0 gnt=1", k, c0_done, c_ram_wen, c0_gnt, k == 4); end
    end
    checks++; if (c0_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL lat3_rdata got=%h exp=deadbeef", c0_rdata); end
    c0_req = 1'b0;
    tick();
    checks++; if (c_busy !== 1'b0 || c0_done !== 1'b0) begin errs++; $display("FAIL lat3_idle got=%b/%b exp=0/0", c_busy, c0_done); end
  endtask

  task automatic test_reset_mid;
    c1_addr = 32'h10; c1_wen = 4'h0; c1_req = 1'b1;
    tick(); tick(); // ISSUE, WAIT
    checks++; if (c1_gnt !== 1'b1 || c_busy !== 1'b1) begin errs++; $display("FAIL rmid_pre got=%b/%b exp=1/1", c1_gnt, c_busy); end
    resetn = 1'b1; #1;
    checks++; if ({c_busy, c0_gnt, c1_gnt, c1_done, c_ram_wen} !== 8'b0 || c_ram_addr !== 32'h0) begin errs++; $display("FAIL rmid_async got=%b/%h exp=0/0", {c_busy, c0_gnt, c1_gnt, c1_done, c_ram_wen}, c_ram_addr); end
    tick();
    resetn = 1'b0;
    c0_addr = 32'h10; c0_wen = 4'h0; c0_req = 1'b1;
    tick(); // ISSUE: tie goes to m0
    checks++; if (c0_gnt !== 1'b1 || c1_gnt !== 1'b0) begin errs++; $display("FAIL rmid_tie got=%b%b exp=10", c0_gnt, c1_gnt); end
    tick(); tick(); // WAIT, WAIT
    checks++; if (c1_done !== 1'b0 || c0_done !== 1'b0) begin errs++; $display("FAIL rmid_stale got=%b%b exp=00", c0_done, c1_done); end
    tick(); // DONE
    checks++; if (c0_done !== 1'b1 || c1_done !== 1'b0 || c0_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rmid_done got=%b%b/%h exp=10/deadbeef", c0_done, c1_done, c0_rdata); end
    c0_req = 1'b0; c1_req = 1'b0;
    tick();
  endtask

  task automatic test_early_drop;
    a0_addr = 32'h30; a0_wen = 4'h3; a0_wdata = 32'hA5A55A5A; a0_req = 1'b1;
    tick(); // ISSUE
    checks++; if (a_ram_wen !== 4'h3 || a_ram_addr !== 32'h30 || a0_gnt !== 1'b1) begin errs++; $display("FAIL drop_issue got=%h/%h/%b exp=3/30/1", a_ram_wen, a_ram_addr, a0_gnt); end
    a0_req = 1'b0; a0_addr = 32'h40; a0_wen = 4'hF; a0_wdata = 32'h0;
    tick(); // DONE
    checks++; if (a0_done !== 1'b1 || a_ram_addr !== 32'h30) begin errs++; $display("FAIL drop_done got=%b/%h exp=1/30", a0_done, a_ram_addr); end
    tick();
    checks++; if (a0_done !== 1'b0 || a_busy !== 1'b0) begin errs++; $display("FAIL drop_once got=%b/%b exp=0/0", a0_done, a_busy); end
    a0_addr = 32'h30; a0_wen = 4'h0; a0_req = 1'b1;
    tick(); tick();
    checks++; if (a0_done !== 1'b1 || a0_rdata !== 32'h11225A5A) begin errs++; $display("FAIL drop_readback got=%b/%h exp=1/11225a5a", a0_done, a0_rdata); end
    a0_req = 1'b0;
    tick();
    a0_addr = 32'h40; a0_wen = 4'h0; a0_req = 1'b1;
    tick(); tick();
    checks++; if (a0_rdata !== 32'h0) begin errs++; $display("FAIL drop_no_late_write got=%h exp=0", a0_rdata); end
    a0_req = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b1;
    a0_req = 0; a0_wen = 0; a0_addr = 0; a0_wdata = 0;
    a1_req = 0; a1_wen = 0; a1_addr = 0; a1_wdata = 0;
    c0_req = 0; c0_wen = 0; c0_addr = 0; c0_wdata = 0;
    c1_req = 0; c1_wen = 0; c1_addr = 0; c1_wdata = 0;
    pl_en = 1'b1; pl_idx = 8'd4;  pl_data = 32'hDEADBEEF; tick();
    pl_idx = 8'd12; pl_data = 32'h11223344; tick();
    pl_idx = 8'd16; pl_data = 32'h0;        tick();
    pl_en = 1'b0;
    test_reset();
    test_read();
    test_write_then_read();
    test_back_to_back();
    test_rdlat3();
    test_reset_mid();
    test_early_drop();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
